div_unit: RTL and testbench
===========================

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width; result width is 2*DATA_W.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
REQ-005 SHALL have port opdata1_i  input  DATA_W  dividend; sampled at start.
REQ-006 SHALL have port opdata2_i  input  DATA_W  divisor; sampled at start.
REQ-007 SHALL have port start_i  input  1  request; level, held high by EX until ready_o is seen.
REQ-008 SHALL have port annul_i  input  1  cancel (pipeline flush/exception).
REQ-009 SHALL have port result_o  output  2*DATA_W  {remainder, quotient}; upper half goes to HI, lower half to LO.
REQ-010 SHALL have port ready_o  output  1  result valid.

Function
REQ-011 SHALL implement states FREE, BYZERO, ON, END; all outputs registered.
REQ-012 FREE: start_i=1 and annul_i=0 SHALL latch operands and signed_div_i, then go to BYZERO if divisor==0, else to ON with iteration count cleared.
REQ-013 FREE: start_i=1 with annul_i=1 SHALL be ignored; the block stays in FREE.
REQ-014 Signed mode SHALL convert negative operands to two's-complement magnitude at latch time; unsigned mode SHALL use operands unmodified.
REQ-015 ON SHALL perform one restoring shift-subtract step per cycle, DATA_W steps total, using a (2*DATA_W+1)-bit working register.
REQ-016 ON, cycle after the final step: SHALL apply sign fix-up, load result_o, set ready_o=1, and go to END.
REQ-017 Sign fix-up (signed mode only): SHALL negate the quotient when operand signs differ and negate the remainder when the dividend is negative; the remainder sign SHALL follow the dividend.
REQ-018 Overflow case -2^(DATA_W-1) / -1 in signed mode SHALL wrap to quotient 0x80000000, remainder 0, with no flag.
REQ-019 Latency SHALL be fixed: with start accepted at edge T, ready_o SHALL first be 1 after edge T+DATA_W+1 (T+33 for DATA_W=32).
REQ-020 BYZERO: next edge SHALL set result_o=0 and ready_o=1 and go to END (ready_o first 1 after edge T+2).
REQ-021 ON: annul_i=1 at any edge SHALL return to FREE with ready_o=0 and result_o=0, and no result SHALL be produced.
REQ-022 END: while start_i=1, SHALL hold result_o and ready_o=1 stably (EX stall window); annul_i SHALL be ignored in END.
REQ-023 END: start_i=0 SHALL return to FREE, clearing ready_o and result_o on the same edge.
REQ-024 Operand or signed_div_i changes after latch SHALL NOT affect the result in progress.
REQ-025 A new start SHALL be accepted no earlier than the first cycle in FREE; there is no back-to-back overlap.

Reset
REQ-026 rst=1 at a rising edge SHALL force state FREE, ready_o=0, result_o=0, and clear the working register and count, in any state including mid-ON.
REQ-027 rst SHALL take priority over start_i and annul_i.

Verification
REQ-028 Unsigned 100/7, start held -> ready_o rises exactly 33 cycles after the accepting edge; result_o = {32'd2, 32'd14}.
REQ-029 Signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x1.
REQ-030 Divide by zero (5/0, both modes) -> ready_o at T+2 with result_o=0; drop start_i -> FREE next edge with outputs 0.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned with same operands -> quotient 0, remainder 0x80000000.
REQ-032 annul_i pulsed 10 cycles into ON -> ready_o never asserts and state is FREE; restart 0xFFFFFFFF/1 unsigned next cycle -> quotient 0xFFFFFFFF, remainder 0 at +33.
REQ-033 rst asserted mid-ON, and separately in END with start_i high -> outputs 0 at the next edge; operands changed during ON -> result unchanged.

Source files
------------

// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// The EX stage drives the request side; the divider answers with result/ready.
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU.
// Result is {remainder, quotient}; fixed latency of DATA_W+1 cycles.
module div_unit #(
    parameter int DATA_W = 32
) (
    input logic      clk,
    input logic      rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int WRK_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t                state_q, state_d;
    logic [WRK_W-1:0]      work_q, work_d;
    logic [DATA_W-1:0]     divisor_q, divisor_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_W-1:0]     mag_a;
    logic [DATA_W-1:0]     mag_b;
    logic [DATA_W+1:0]     part;
    logic [DATA_W:0]       diff;
    logic                  fits;
    logic [DATA_W-1:0]     quo;
    logic [DATA_W-1:0]     rem;

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;

    // Operand magnitudes and a single restoring step on the working register.
    always_comb begin
        sign_a = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        sign_b = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
        mag_a  = sign_a ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
        mag_b  = sign_b ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
        // Partial remainder shifted left with the next dividend bit appended.
        part   = work_q[WRK_W-1:DATA_W-1];
        diff   = part[DATA_W:0] - {1'b0, divisor_q};
        fits   = part >= {2'b00, divisor_q};
        quo    = neg_quo_q ? (~work_q[DATA_W-1:0] + 1'b1)
                           : work_q[DATA_W-1:0];
        rem    = neg_rem_q ? (~work_q[2*DATA_W-1:DATA_W] + 1'b1)
                           : work_q[2*DATA_W-1:DATA_W];
    end

    // Next-state and next-output logic for the divider FSM.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;
        unique case (state_q)
            FREE: begin
                if (bus.start_i && !bus.annul_i) begin
                    work_d    = {{(DATA_W+1){1'b0}}, mag_a};
                    divisor_d = mag_b;
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    cnt_d     = '0;
                    if (bus.opdata2_i == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                    end
                end
            end
            BYZERO: begin
                // One settling cycle keeps divide-by-zero on a T+2 answer.
                if (bus.annul_i) begin
                    state_d = FREE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = END;
                end
            end
            ON: begin
                if (bus.annul_i) begin
                    state_d  = FREE;
                    work_d   = '0;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    if (fits) begin
                        work_d = {diff, work_q[DATA_W-2:0], 1'b1};
                    end else begin
                        work_d = {part[DATA_W:0], work_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    result_d = {rem, quo};
                    ready_d  = 1'b1;
                    state_d  = END;
                end
            end
            END: begin
                if (!bus.start_i) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d = FREE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            work_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: timing, signed/unsigned results,
// divide-by-zero, annul, reset and operand-stability cases.
module tb_div_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    div_unit_if #(.DATA_W(32)) bus ();

    div_unit #(.DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sg, input logic [31:0] a,
                         input logic [31:0] b);
        bus.signed_div_i = sg;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
    endtask

    // Full transaction: accept at T, expect ready exactly after T+33,
    // hold in END, then release and expect cleared outputs.
    task automatic run_div(input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input string tag, input bit scramble);
        logic early;
        early = 1'b0;
        drive(sg, a, b);
        step();
        for (int i = 1; i <= 32; i++) begin
            step();
            if (scramble && i == 1) begin
                bus.signed_div_i = ~sg;
                bus.opdata1_i    = $urandom;
                bus.opdata2_i    = $urandom;
            end
            if (bus.ready_o !== 1'b0) early = 1'b1;
        end
        chk({tag, "_early"}, {63'd0, early}, 64'd0);
        step();
        chk({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
        chk({tag, "_result"}, bus.result_o, exp);
        step();
        chk({tag, "_hold_rdy"}, {63'd0, bus.ready_o}, 64'd1);
        chk({tag, "_hold_res"}, bus.result_o, exp);
        bus.start_i = 1'b0;
        step();
        chk({tag, "_rel_rdy"}, {63'd0, bus.ready_o}, 64'd0);
        chk({tag, "_rel_res"}, bus.result_o, 64'd0);
    endtask

    task automatic run_zero(input logic sg, input string tag);
        drive(sg, 32'd5, 32'd0);
        step();
        step();
        chk({tag, "_t1_rdy"}, {63'd0, bus.ready_o}, 64'd0);
        step();
        chk({tag, "_t2_rdy"}, {63'd0, bus.ready_o}, 64'd1);
        chk({tag, "_t2_res"}, bus.result_o, 64'd0);
        bus.start_i = 1'b0;
        step();
        chk({tag, "_rel_rdy"}, {63'd0, bus.ready_o}, 64'd0);
        chk({tag, "_rel_res"}, bus.result_o, 64'd0);
    endtask

    initial begin
        logic seen;
        checks           = 0;
        errors           = 0;
        rst              = 1'b1;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        step();
        step();
        chk("reset_rdy", {63'd0, bus.ready_o}, 64'd0);
        chk("reset_res", bus.result_o, 64'd0);
        rst = 1'b0;
        step();

        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "u100_7", 1'b0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'h2,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_2", 1'b0);
        run_div(1'b1, 32'h7, 32'hFFFF_FFFE,
                {32'h1, 32'hFFFF_FFFD}, "s_7_m2", 1'b0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h0, 32'h8000_0000}, "s_ovf", 1'b0);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h8000_0000, 32'h0}, "u_big", 1'b0);
        run_zero(1'b0, "uzero");
        run_zero(1'b1, "szero");

        // Annul ten cycles into ON, then restart immediately.
        drive(1'b0, 32'd1000, 32'd3);
        step();
        for (int i = 0; i < 10; i++) step();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        step();
        bus.annul_i = 1'b0;
        chk("annul_rdy", {63'd0, bus.ready_o}, 64'd0);
        chk("annul_res", bus.result_o, 64'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h1,
                {32'h0, 32'hFFFF_FFFF}, "restart", 1'b0);

        // Annul in FREE with start high is ignored.
        bus.annul_i = 1'b1;
        drive(1'b0, 32'd9, 32'd0);
        step();
        step();
        step();
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        chk("free_annul_rdy", {63'd0, bus.ready_o}, 64'd0);
        step();

        // Reset in the middle of ON.
        drive(1'b0, 32'd100, 32'd7);
        step();
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        chk("rst_on_rdy", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_on_res", bus.result_o, 64'd0);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        seen        = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        chk("rst_on_quiet", {63'd0, seen}, 64'd0);

        // Reset while in END with start still high.
        drive(1'b0, 32'd50, 32'd5);
        step();
        for (int i = 0; i < 33; i++) step();
        chk("end_pre_rdy", {63'd0, bus.ready_o}, 64'd1);
        chk("end_pre_res", bus.result_o, {32'd0, 32'd10});
        rst = 1'b1;
        step();
        chk("rst_end_rdy", {63'd0, bus.ready_o}, 64'd0);
        chk("rst_end_res", bus.result_o, 64'd0);
        rst         = 1'b0;
        bus.start_i = 1'b0;
        step();

        // Operands and mode scrambled after latch.
        run_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, "stable", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
